// File: rtl/adder_fu_pipe.sv
// Elastic scalar adder functional unit: ADD/SUB/MIN/MAX over a STAGES-deep valid/ready pipeline.
// Define ADDER_FU_SAT_EN to clamp ADD/SUB results to the signed range on overflow.
module adder_fu_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             on_off,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             carry,
    output logic             ovf,
    output logic             ack
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MIN = 2'b10,
        OP_MAX = 2'b11
    } op_e;

    // Stage payload layout: {ovf, carry, c}
    localparam int DW = WIDTH + 2;

    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   dif_w;
    logic             a_lt_b;
    logic             a_gt_b;
    logic [WIDTH-1:0] res_d;
    logic             res_carry_d;
    logic             res_ovf_d;

    always_comb begin
        sum_w       = {1'b0, a} + {1'b0, b};
        dif_w       = {1'b0, a} - {1'b0, b};
        a_lt_b      = $signed(a) < $signed(b);
        a_gt_b      = $signed(a) > $signed(b);
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        res_d       = a;
        res_carry_d = 1'b0;
        res_ovf_d   = 1'b0;
        case (op_e'(op))
            OP_ADD: begin
                res_d       = sum_w[WIDTH-1:0];
                res_carry_d = sum_w[WIDTH];
                res_ovf_d   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res_d       = dif_w[WIDTH-1:0];
                res_carry_d = dif_w[WIDTH];
                res_ovf_d   = (a[WIDTH-1] != b[WIDTH-1]) && (dif_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_MIN: res_d = a_gt_b ? b : a;
            OP_MAX: res_d = a_lt_b ? b : a;
        endcase
`ifdef ADDER_FU_SAT_EN
        // Overflow direction follows the sign of a: positive a can only overflow upward.
        if (res_ovf_d)
            res_d = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    end

    logic [STAGES:1] vld_q;
    logic [DW-1:0]   dat_q [1:STAGES];
    logic [STAGES:1] rdy;
    logic            in_fire;

    // A stage is ready unless it and every stage downstream are full while the consumer stalls.
    always_comb begin : rdy_chain
        logic full_tail;
        full_tail = 1'b1;
        rdy       = '0;
        for (int i = STAGES; i >= 1; i--) begin
            full_tail = full_tail & vld_q[i];
            rdy[i]    = !full_tail | out_ready;
        end
    end

    assign in_ready = rdy[1] & on_off & !reset;
    assign in_fire  = in_valid & in_ready;

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || !on_off) begin
            vld_q <= '0;
            // NOTE: payload registers are cleared too, because the last stage drives c/carry/ovf.
            for (int i = 1; i <= STAGES; i++) dat_q[i] <= '0;
        end else begin
            if (rdy[1]) begin
                vld_q[1] <= in_fire;
                if (in_fire) dat_q[1] <= {res_ovf_d, res_carry_d, res_d};
            end
            for (int i = 2; i <= STAGES; i++) begin
                if (rdy[i]) begin
                    vld_q[i] <= vld_q[i-1];
                    if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign out_valid         = vld_q[STAGES];
    assign {ovf, carry, c}   = dat_q[STAGES];
    assign ack               = out_valid & out_ready;

endmodule

// File: tb/tb_adder_fu_pipe.sv
// Bench for adder_fu_pipe: directed scenarios plus random traffic against a queue-based latency model.
module tb_adder_fu_pipe;

    localparam int W = 16;
    localparam int S = 2;
    localparam longint MAXS = (64'sd1 <<< (W - 1)) - 1;
    localparam longint MINS = -(64'sd1 <<< (W - 1));
    localparam longint MODW = 64'sd1 <<< W;

    logic         clk;
    logic         reset;
    logic         on_off;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] c;
    logic         carry;
    logic         ovf;
    logic         ack;

    adder_fu_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk      (clk),
        .reset    (reset),
        .on_off   (on_off),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .op       (op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .c        (c),
        .carry    (carry),
        .ovf      (ovf),
        .ack      (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] c;
        logic         carry;
        logic         ovf;
    } res_t;

    typedef struct {
        res_t r;
        int   t;
    } ent_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   n_ack = 0;
    int   cyc = 0;
    int   last_dep = 0;
    bit   armed = 1'b0;
    bit   flushed = 1'b0;
    ent_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Plain-integer reference for one operation.
    function automatic res_t ref_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] o);
        res_t   r;
        longint sx, sy, s, ux, uy;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r  = '0;
        s  = 0;
        case (o)
            2'd0, 2'd1: begin
                if (o == 2'd0) begin
                    s       = sx + sy;
                    r.carry = (ux + uy) >= MODW;
                end else begin
                    s       = sx - sy;
                    r.carry = ux < uy;
                end
                r.ovf = (s > MAXS) || (s < MINS);
                r.c   = s[W-1:0];
`ifdef ADDER_FU_SAT_EN
                if (r.ovf) r.c = (s > 0) ? W'(MAXS) : W'(MINS);
`endif
            end
            2'd2: r.c = (sy < sx) ? y : x;
            default: r.c = (sy > sx) ? y : x;
        endcase
        return r;
    endfunction

    // Capacity S; the head beat shows S-1 edges after acceptance, or on the edge its predecessor left.
    function automatic bit m_out_valid();
        if (q.size() == 0) return 1'b0;
        return (cyc >= q[0].t) && (cyc >= last_dep);
    endfunction

    function automatic bit m_in_ready();
        return !reset && on_off && ((q.size() < S) || out_ready);
    endfunction

    always @(posedge clk) begin : model
        bit   rdy_m;
        bit   ov_m;
        ent_t e;
        rdy_m = m_in_ready();
        ov_m  = m_out_valid();
        if (ack) n_ack++;
        cyc++;
        if (reset || !on_off) begin
            q.delete();
            last_dep = 0;
            flushed  = 1'b1;
            if (reset) armed = 1'b1;
        end else begin
            flushed = 1'b0;
            if (ov_m && out_ready) begin
                void'(q.pop_front());
                last_dep = cyc;
            end
            if (in_valid && rdy_m) begin
                e.r = ref_op(a, b, op);
                e.t = cyc + S - 1;
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin : compare
        bit ov_m;
        if (armed) begin
            ov_m = m_out_valid();
            check("out_valid", out_valid, ov_m);
            check("in_ready", in_ready, m_in_ready());
            check("ack", ack, ov_m & out_ready);
            if (ov_m) begin
                check("c", c, q[0].r.c);
                check("carry", carry, q[0].r.carry);
                check("ovf", ovf, q[0].r.ovf);
            end
            if (flushed) begin
                check("clr_c", c, 0);
                check("clr_carry", carry, 0);
                check("clr_ovf", ovf, 0);
            end
        end
    end

    task automatic drive(input bit rst, input bit en, input bit iv, input logic [W-1:0] aa,
                         input logic [W-1:0] bb, input logic [1:0] oo, input bit ordy);
        @(posedge clk);
        #1;
        reset     = rst;
        on_off    = en;
        in_valid  = iv;
        a         = aa;
        b         = bb;
        op        = oo;
        out_ready = ordy;
    endtask

    function automatic logic [W-1:0] rand_val();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return W'(MAXS);
            2: return W'(MINS);
            3: return '1;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin : stim
        res_t r;
        int   base;
        int   i;
        int   cnt;
        bit   acc;

        reset = 1'b1; on_off = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = 2'd0; out_ready = 1'b1;

        // Hand-computed expectations pin the reference function.
        r = ref_op(16'h0003, 16'h0004, 2'd0);
        check("pin_add_c", r.c, 16'h0007);
        check("pin_add_carry", r.carry, 0);
        r = ref_op(16'h7FFF, 16'h0001, 2'd0);
`ifdef ADDER_FU_SAT_EN
        check("pin_ovf_c", r.c, 16'h7FFF);
`else
        check("pin_ovf_c", r.c, 16'h8000);
`endif
        check("pin_ovf_flag", r.ovf, 1);
        check("pin_ovf_carry", r.carry, 0);
        r = ref_op(16'h0000, 16'h0001, 2'd1);
        check("pin_sub_c", r.c, 16'hFFFF);
        check("pin_sub_borrow", r.carry, 1);
        check("pin_sub_ovf", r.ovf, 0);
        r = ref_op(16'hFFFE, 16'h0001, 2'd2);
        check("pin_min", r.c, 16'hFFFE);
        r = ref_op(16'hFFFE, 16'h0001, 2'd3);
        check("pin_max", r.c, 16'h0001);
        r = ref_op(16'h8000, 16'h8000, 2'd0);
        check("pin_negovf_carry", r.carry, 1);

        repeat (3) drive(1, 1, 0, 0, 0, 0, 1);

        // 3 + 4 accepted at one edge, visible on the cycle two cycles after it was driven.
        drive(0, 1, 1, 16'h0003, 16'h0004, 2'd0, 1);
        drive(0, 1, 0, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 0, 0, 1);
        @(negedge clk);
        check("t1_valid", out_valid, 1);
        check("t1_c", c, 16'h0007);
        check("t1_ack", ack, 1);
        check("t1_flags", {carry, ovf}, 2'b00);

        // Overflow, borrow and signed compare corners back to back.
        drive(0, 1, 1, 16'h7FFF, 16'h0001, 2'd0, 1);
        drive(0, 1, 1, 16'h0000, 16'h0001, 2'd1, 1);
        drive(0, 1, 1, 16'hFFFE, 16'h0001, 2'd2, 1);
        drive(0, 1, 1, 16'hFFFE, 16'h0001, 2'd3, 1);
        drive(0, 1, 1, 16'h1234, 16'h1234, 2'd2, 1);
        drive(0, 1, 1, 16'h8000, 16'h0001, 2'd1, 1);
        repeat (4) drive(0, 1, 0, 0, 0, 0, 1);

        // Eight-beat stream with the consumer stalled for cycles 3-6.
        base = n_ack;
        i = 0;
        cnt = 0;
        while (i < 8 && cnt < 40) begin
            cnt++;
            drive(0, 1, 1, W'(i), 16'h0001, 2'd0, !(cnt >= 3 && cnt <= 6));
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) i++;
        end
        check("stream_accepted", i, 8);
        repeat (6) drive(0, 1, 0, 0, 0, 0, 1);
        check("stream_results", n_ack - base, 8);

        // Two beats in flight, one-cycle disable, then a lone beat.
        drive(0, 1, 1, 16'h0010, 16'h0020, 2'd0, 0);
        drive(0, 1, 1, 16'h0030, 16'h0040, 2'd0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 16'h0100, 16'h0001, 2'd1, 1);
        repeat (4) drive(0, 1, 0, 0, 0, 0, 1);

        // Reset mid-stream with a stalled consumer, then full-rate streaming.
        for (int k = 0; k < 4; k++) drive(0, 1, 1, W'(k + 100), 16'h0002, 2'd0, 0);
        drive(1, 1, 1, 16'h5555, 16'h0001, 2'd0, 0);
        for (int k = 0; k < 10; k++) drive(0, 1, 1, W'(k * 7), W'(k), 2'(k), 1);
        repeat (3) drive(0, 1, 0, 0, 0, 0, 1);

        // Random traffic with occasional disable and reset.
        for (int k = 0; k < 3000; k++)
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 49) != 0,
                  $urandom_range(0, 3) != 0, rand_val(), rand_val(),
                  2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);

        repeat (5) drive(0, 1, 0, 0, 0, 0, 1);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
